nibble_add_seq: RTL
===================

Name: nibble_add_seq

Overview:
- Multi-cycle sequencer that time-shares one adder_4bit slice to perform 16-bit arithmetic one nibble per cycle.
- Supports two operations:
  - ADD16: signed 16-bit add with carry chained across nibbles, saturating on overflow.
  - PADDSB: four independent signed 4-bit saturating adds.
- Sits beside the ALU as the area-reduced alternative to the four-slice combinational adder. It is driven by the ALU control with a start/done handshake.

Parameters:
- NIB_W, 4, width of the shared adder slice.
- NUM_NIB, 4, nibbles per operand; the operand width is NIB_W*NUM_NIB.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = ADD16, 1 = PADDSB; latched with start.
- A  input  16  operand A; latched with start.
- B  input  16  operand B; latched with start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result valid.
- Sum  output  16  result; held until the next accepted start.
- ovfl  output  4  per-nibble saturation flags. For ADD16, only ovfl[3] is used and ovfl[2:0] = 0.

Behaviour:
- Reset (async, any state): state = IDLE, cnt = 0, carry = 0. busy, done, Sum and ovfl are all 0. Latched operands are cleared.
- States:
  - IDLE: start=1 latches op, A and B; clears Sum, ovfl and carry; sets cnt = 0; goes to RUN. start=0 stays in IDLE.
  - RUN: each cycle computes nibble cnt through the single adder_4bit. The result is written into Sum[4*cnt+3:4*cnt] and ovfl[cnt] is updated. cnt increments. Once cnt = 3 has been processed, go to DONE.
  - DONE: done = 1 for exactly this cycle; next edge goes to IDLE.
- Latency: start high in cycle 0 gives done high in cycle 5. The minimum start-to-start spacing is 6 cycles.
- start while in RUN or DONE: ignored, no queuing. op, A and B changes after acceptance: no effect.
- Carry-in:
  - ADD16: nibble 0 gets cin = 0; later nibbles get the registered Cout of the previous nibble.
  - PADDSB: cin = 0 for every nibble and the carry register is unused.
- PADDSB saturation, per nibble: on signed 4-bit overflow, a positive result (both operands positive) becomes 4'h7 and a negative result becomes 4'h8. ovfl[i] = 1 for a saturated nibble, else 0.
- ADD16 saturation, evaluated on the nibble-3 cycle using the slice ovfl: if overflow, the whole Sum is overwritten with 16'h7FFF (A[15] = 0) or 16'h8000 (A[15] = 1), and ovfl = 4'b1000. Otherwise ovfl = 4'b0000.
- Sum and ovfl are registered. Partial values are visible during RUN and are valid only when done = 1 and afterwards.
- Reset mid-RUN aborts the operation: no done pulse and all outputs return to 0.

Decomposition:
- Shared defines header holds:
  - op encodings OP_ADD16 = 1'b0 and OP_PADDSB = 1'b1;
  - state encodings S_IDLE, S_RUN, S_DONE;
  - the saturation constants SAT_POS4 = 4'h7, SAT_NEG4 = 4'h8, SAT_POS16 = 16'h7FFF, SAT_NEG16 = 16'h8000.
- The one sub-module is the existing adder_4bit, instantiated exactly once and fed by nibble-select muxes on the latched A and B.
- The FSM, nibble counter and saturation logic stay in this module.

Test Plan:
- ADD16 A=16'h1234, B=16'h1111, start in cycle 0 -> done in cycle 5 with Sum = 16'h2345, ovfl = 4'b0000. busy high in cycles 1-4.
- ADD16 A=16'h7FFF, B=16'h0001 -> Sum = 16'h7FFF, ovfl = 4'b1000. Separately A=16'h8000, B=16'hFFFF -> Sum = 16'h8000, ovfl = 4'b1000.
- PADDSB A=16'h7171, B=16'h1717 -> Sum = 16'h7777, ovfl = 4'b1111. Separately A=16'h8823, B=16'h8F11 -> Sum = 16'h8834, ovfl = 4'b1100.
- PADDSB A=16'h00F0, B=16'h0010 -> Sum = 16'h0000, ovfl = 4'b0000. This confirms no carry leaks from nibble 1 into nibble 2.
- Start ADD16 16'h0001+16'h0001, then pulse start with op = PADDSB and new operands in cycle 2 -> the second request is ignored; done in cycle 5 with Sum = 16'h0002. A new start in cycle 6 is accepted.
- Assert rst in cycle 3 of a run -> busy, done, Sum and ovfl go to 0 immediately, with no done pulse. A new start after rst release completes normally.

Source files
------------

// File: rtl/nibble_add_seq_pkg.sv
// nibble_add_seq_pkg
//   Shared definitions for the nibble-serial adder: slice geometry, op and
//   state encodings, and the saturation constants.
package nibble_add_seq_pkg;

  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 4;
  localparam int WORD_W  = NIB_W * NUM_NIB;
  localparam int CNT_W   = 2;

  localparam logic OP_ADD16  = 1'b0;
  localparam logic OP_PADDSB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [NIB_W-1:0]   SAT_POS4  = 4'h7;
  localparam logic [NIB_W-1:0]   SAT_NEG4  = 4'h8;
  localparam logic [WORD_W-1:0]  SAT_POS16 = 16'h7FFF;
  localparam logic [WORD_W-1:0]  SAT_NEG16 = 16'h8000;

  localparam logic [CNT_W-1:0]   LAST_NIB    = CNT_W'(NUM_NIB - 1);
  localparam logic [NUM_NIB-1:0] OVFL_ADD16  = 4'b1000;

  // Saturated nibble value chosen by the sign of the operands (both operands
  // share a sign whenever signed overflow occurs).
  function automatic logic [NIB_W-1:0] sat4(input logic neg);
    return neg ? SAT_NEG4 : SAT_POS4;
  endfunction

endpackage

// File: rtl/nibble_add_seq_adder_4bit.sv
// adder_4bit
//   Single 4-bit adder slice with carry in/out and signed-overflow flag.
//   Ports:
//     a_i, b_i  - 4-bit operands
//     cin_i     - carry in
//     sum_o     - 4-bit sum
//     cout_o    - carry out
//     ovfl_o    - signed two's-complement overflow of this slice
module adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o,
  output logic       ovfl_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

  // Overflow: operands agree in sign but the result does not.
  assign ovfl_o = (a_i[3] == b_i[3]) && (sum_o[3] != a_i[3]);

endmodule

// File: rtl/nibble_add_seq.sv
// nibble_add_seq
//   Nibble-serial 16-bit adder that time-shares one adder_4bit slice.
//   op = ADD16  : signed 16-bit add, carry chained through a register,
//                 saturated to 7FFF/8000 on overflow.
//   op = PADDSB : four independent signed 4-bit saturating adds.
//   Ports:
//     clk, rst     - clock (rising edge), async active-high reset
//     start        - request, sampled only in IDLE; latches op, A, B
//     op, A, B     - operation select and 16-bit operands
//     busy         - high while nibbles are being computed (RUN)
//     done         - one-cycle pulse, Sum/ovfl valid
//     Sum, ovfl    - registered result and per-nibble saturation flags
//     dbg_state_o  - current FSM state for observation
//   Handshake: start is accepted only when busy=0 and done=0 (IDLE); the
//   result is valid on the done cycle and held until the next accepted
//   start. Requests arriving in RUN or DONE are dropped, not queued.
module nibble_add_seq
  import nibble_add_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] Sum,
  output logic [NUM_NIB-1:0] ovfl,
  output logic [1:0]        dbg_state_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               op_q, op_d;
  logic [WORD_W-1:0]  a_q, a_d;
  logic [WORD_W-1:0]  b_q, b_d;
  logic [WORD_W-1:0]  sum_q, sum_d;
  logic [NUM_NIB-1:0] ovfl_q, ovfl_d;

  logic [NIB_W-1:0]   nib_a, nib_b, add_sum;
  logic               add_cin, add_cout, add_ovf;

  // Nibble-select muxes on the latched operands.
  assign nib_a = a_q[cnt_q*NIB_W +: NIB_W];
  assign nib_b = b_q[cnt_q*NIB_W +: NIB_W];

  // Nibble 0 of ADD16 and every PADDSB nibble start with no carry.
  assign add_cin = (op_q == OP_ADD16) && (cnt_q != '0) && carry_q;

  adder_4bit u_adder (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout),
    .ovfl_o (add_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= OP_ADD16;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovfl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      ovfl_q  <= ovfl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ovfl_d  = ovfl_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = A;
          b_d     = B;
          sum_d   = '0;
          ovfl_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q == OP_PADDSB) begin
          carry_d = 1'b0;
          sum_d[cnt_q*NIB_W +: NIB_W] = add_ovf ? sat4(nib_a[NIB_W-1]) : add_sum;
          ovfl_d[cnt_q] = add_ovf;
        end else begin
          carry_d = add_cout;
          sum_d[cnt_q*NIB_W +: NIB_W] = add_sum;
          // Only the top nibble's overflow is a 16-bit signed overflow.
          if (cnt_q == LAST_NIB) begin
            if (add_ovf) begin
              sum_d  = a_q[WORD_W-1] ? SAT_NEG16 : SAT_POS16;
              ovfl_d = OVFL_ADD16;
            end else begin
              ovfl_d = '0;
            end
          end
        end
        if (cnt_q == LAST_NIB) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign Sum         = sum_q;
  assign ovfl        = ovfl_q;
  assign dbg_state_o = state_q;

endmodule
